// File: rtl/escalonador_pkg.sv
// Shared definitions for the floor scheduler: state codes, sweep direction and timer defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package escalonador_pkg;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        MEDE   = 3'd1,
        DECIDE = 3'd2,
        SOBE   = 3'd3,
        DESCE  = 3'd4,
        PORTA  = 3'd5,
        ERRO   = 3'd6
    } estado_t;

    localparam logic DIR_SOBE  = 1'b1;
    localparam logic DIR_DESCE = 1'b0;

    localparam int N_ANDARES             = 4;
    localparam int LARGURA_TEMP          = 16;
    localparam int PERIODO_MEDIDA_PADRAO = 50;
    localparam int CICLOS_PORTA_PADRAO   = 100;
    localparam int CICLOS_TIMEOUT_PADRAO = 1000;

    function automatic logic [N_ANDARES-1:0] mascara_andar(input logic [1:0] andar);
        return N_ANDARES'(1) << andar;
    endfunction

endpackage

// File: rtl/escalonador_andar_if.sv
// Bundle between the scheduler (slave) and its environment: calls, floor sensor, car commands, status.
// Latency: n/a (wires only).
// Backpressure: none; pronto_medida is a one-cycle strobe answering medir.
interface escalonador_andar_if;
    import escalonador_pkg::*;

    logic [N_ANDARES-1:0] botoes;
    logic [1:0]           andar_atual;
    logic                 pronto_medida;
    logic                 medir;
    logic                 motor_sobe;
    logic                 motor_desce;
    logic                 porta_aberta;
    logic [N_ANDARES-1:0] pendentes;
    logic                 direcao;
    logic [2:0]           estado_db;
    logic                 erro;

    modport master (
        output botoes, andar_atual, pronto_medida,
        input  medir, motor_sobe, motor_desce, porta_aberta, pendentes, direcao, estado_db, erro
    );

    modport slave (
        input  botoes, andar_atual, pronto_medida,
        output medir, motor_sobe, motor_desce, porta_aberta, pendentes, direcao, estado_db, erro
    );
endinterface

// File: rtl/temporizador_ciclos.sv
// Load/decrement cycle counter; zero flags expiry and the count saturates there.
// Latency: load/decrement take effect at the next clock edge.
// Backpressure: none; load wins over decrement.
module temporizador_ciclos #(
    parameter int LARGURA = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carregar,
    input  logic [LARGURA-1:0] valor,
    input  logic               decrementar,
    output logic               zero
);
    logic [LARGURA-1:0] contagem;

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= '0;
        end else if (carregar) begin
            contagem <= valor;
        end else if (decrementar && contagem != '0) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign zero = (contagem == '0);
endmodule

// File: rtl/escalonador_andar.sv
// Four-floor elevator sweep scheduler; optional stuck-car watchdog under WATCHDOG_EN.
// Latency: calls registered next cycle; one measure/decide round per PERIODO_MEDIDA while moving.
// Backpressure: waits indefinitely in MEDE for pronto_medida; strobes elsewhere are ignored.
module escalonador_andar
    import escalonador_pkg::*;
#(
    parameter int PERIODO_MEDIDA = PERIODO_MEDIDA_PADRAO,
    parameter int CICLOS_PORTA   = CICLOS_PORTA_PADRAO,
    parameter int CICLOS_TIMEOUT = CICLOS_TIMEOUT_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    escalonador_andar_if.slave bus
);
    localparam int MAX_CARGA = 1 << LARGURA_TEMP;

    if (PERIODO_MEDIDA < 1 || PERIODO_MEDIDA > MAX_CARGA ||
        CICLOS_PORTA   < 1 || CICLOS_PORTA   > MAX_CARGA ||
        CICLOS_TIMEOUT < 1 || CICLOS_TIMEOUT > MAX_CARGA) begin : g_parametro_invalido
        $error("escalonador_andar: timer parameter does not fit the cycle counter");
    end

    localparam logic [LARGURA_TEMP-1:0] CARGA_MOV   = LARGURA_TEMP'(PERIODO_MEDIDA - 1);
    localparam logic [LARGURA_TEMP-1:0] CARGA_PORTA = LARGURA_TEMP'(CICLOS_PORTA - 1);

    estado_t              estado_q, estado_d;
    logic [N_ANDARES-1:0] pend_q, pend_d;
    logic [1:0]           andar_q, andar_d;
    logic                 dir_q, dir_d;
    logic                 medir_q;
    logic                 sobe_q, sobe_d, desce_q, desce_d;

    logic [N_ANDARES-1:0] bit_andar, mascara_acima, mascara_abaixo;
    logic                 dir_forcada, chamada_acima, chamada_abaixo;
    logic                 mov_carregar, mov_dec, mov_zero;
    logic                 porta_carregar, porta_dec, porta_zero;
    logic                 mantem_motor, em_porta;

    assign bit_andar      = mascara_andar(andar_q);
    assign mascara_abaixo = bit_andar - N_ANDARES'(1);
    assign mascara_acima  = ~(mascara_abaixo | bit_andar);
    assign chamada_acima  = |(pend_q & mascara_acima);
    assign chamada_abaixo = |(pend_q & mascara_abaixo);
    assign dir_forcada    = (andar_q == 2'd3) ? DIR_DESCE :
                            (andar_q == 2'd0) ? DIR_SOBE  : dir_q;

`ifdef WATCHDOG_EN
    // Any measurement that moves the car re-arms the watchdog; it only runs with a motor on.
    logic movendo, wd_carregar, wd_zero, wd_disparo;
    assign movendo     = sobe_q | desce_q;
    assign wd_carregar = !movendo ||
                         (estado_q == MEDE && bus.pronto_medida && bus.andar_atual != andar_q);
    assign wd_disparo  = movendo && wd_zero;

    temporizador_ciclos #(.LARGURA(LARGURA_TEMP)) u_temp_watchdog (
        .clock       (clock),
        .reset       (reset),
        .carregar    (wd_carregar),
        .valor       (LARGURA_TEMP'(CICLOS_TIMEOUT - 1)),
        .decrementar (movendo),
        .zero        (wd_zero)
    );
`endif

    always_comb begin
        estado_d       = estado_q;
        andar_d        = andar_q;
        dir_d          = dir_q;
        mov_carregar   = 1'b0;
        mov_dec        = 1'b0;
        porta_carregar = 1'b0;
        porta_dec      = 1'b0;

        case (estado_q)
            OCIOSO: if (pend_q != '0) estado_d = MEDE;
            MEDE: begin
                if (bus.pronto_medida) begin
                    andar_d  = bus.andar_atual;
                    estado_d = DECIDE;
                end
            end
            DECIDE: begin
                if ((pend_q & bit_andar) != '0) begin
                    estado_d       = PORTA;
                    porta_carregar = 1'b1;
                end else if (pend_q == '0) begin
                    estado_d = OCIOSO;
                end else begin
                    // Keep sweeping while calls remain ahead, otherwise turn around.
                    if (dir_forcada == DIR_SOBE) dir_d = chamada_acima  ? DIR_SOBE  : DIR_DESCE;
                    else                         dir_d = chamada_abaixo ? DIR_DESCE : DIR_SOBE;
                    estado_d     = (dir_d == DIR_SOBE) ? SOBE : DESCE;
                    mov_carregar = 1'b1;
                end
            end
            SOBE, DESCE: begin
                if (mov_zero) estado_d = MEDE;
                else          mov_dec  = 1'b1;
            end
            PORTA: begin
                if (|(bus.botoes & bit_andar)) porta_carregar = 1'b1;
                else if (porta_zero)           estado_d = (pend_q != '0) ? MEDE : OCIOSO;
                else                           porta_dec = 1'b1;
            end
`ifdef WATCHDOG_EN
            ERRO: estado_d = ERRO;
`endif
            default: estado_d = OCIOSO;
        endcase

`ifdef WATCHDOG_EN
        if (wd_disparo) estado_d = ERRO;
`endif

        // The open floor's own button only extends the door; it never re-queues the call.
        em_porta = (estado_q == PORTA) || (estado_d == PORTA);
        pend_d   = pend_q | bus.botoes;
        if (em_porta) pend_d = pend_d & ~bit_andar;

        mantem_motor = (estado_d == MEDE) || (estado_d == DECIDE);
        sobe_d       = (estado_d == SOBE)  || (mantem_motor && sobe_q);
        desce_d      = (estado_d == DESCE) || (mantem_motor && desce_q);
    end

    temporizador_ciclos #(.LARGURA(LARGURA_TEMP)) u_temp_movimento (
        .clock       (clock),
        .reset       (reset),
        .carregar    (mov_carregar),
        .valor       (CARGA_MOV),
        .decrementar (mov_dec),
        .zero        (mov_zero)
    );

    temporizador_ciclos #(.LARGURA(LARGURA_TEMP)) u_temp_porta (
        .clock       (clock),
        .reset       (reset),
        .carregar    (porta_carregar),
        .valor       (CARGA_PORTA),
        .decrementar (porta_dec),
        .zero        (porta_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            pend_q   <= '0;
            andar_q  <= '0;
            dir_q    <= DIR_SOBE;
            medir_q  <= 1'b0;
            sobe_q   <= 1'b0;
            desce_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pend_q   <= pend_d;
            andar_q  <= andar_d;
            dir_q    <= dir_d;
            medir_q  <= (estado_d == MEDE) && (estado_q != MEDE);
            sobe_q   <= sobe_d;
            desce_q  <= desce_d;
        end
    end

    assign bus.medir        = medir_q;
    assign bus.motor_sobe   = sobe_q;
    assign bus.motor_desce  = desce_q;
    assign bus.porta_aberta = (estado_q == PORTA);
    assign bus.pendentes    = pend_q;
    assign bus.direcao      = dir_q;
    assign bus.estado_db    = estado_q;
`ifdef WATCHDOG_EN
    assign bus.erro         = (estado_q == ERRO);
`else
    assign bus.erro         = 1'b0;
`endif
endmodule
